// File: rtl/gray_fifo_pkg.sv
// Shared helpers for the Gray-coded FIFO pointer controller: pointer sizing
// and binary-to-Gray encoding.
package gray_fifo_pkg;

    localparam int DEPTH_W_DEF = 4;
    // Widest pointer the controller supports (DEPTH_W up to 16).
    localparam int MAX_PTR_W   = 17;

    typedef logic [MAX_PTR_W-1:0] ptr_max_t;

    function automatic int ptr_w(input int depth_w);
        return depth_w + 1;
    endfunction

    function automatic int depth(input int depth_w);
        return 2 ** depth_w;
    endfunction

    // Callers zero-extend into the widest pointer and truncate the result;
    // the low bits are exact because the high input bits are zero.
    function automatic ptr_max_t bin2gray(input ptr_max_t b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_fifo_gray2bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all
// Gray bits at and above its position.
module gray_fifo_gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_bin[i] = ^(i_gray >> i);
    end

endmodule

// File: rtl/gray_fifo_ctrl.sv
// Single-clock FIFO pointer controller with Gray-coded pointers, registered
// full/empty/occupancy and one-cycle reject pulses.
module gray_fifo_ctrl
    import gray_fifo_pkg::*;
#(
    parameter int DEPTH_W = DEPTH_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               w_req,
    input  logic               r_req,
    output logic               w_en,
    output logic               r_en,
    output logic [DEPTH_W-1:0] w_addr,
    output logic [DEPTH_W-1:0] r_addr,
    output logic [DEPTH_W:0]   w_ptr_gray,
    output logic [DEPTH_W:0]   r_ptr_gray,
    output logic               full,
    output logic               empty,
    output logic [DEPTH_W:0]   usedw,
    output logic               w_fail,
    output logic               r_fail
);

    localparam int PTR_W = ptr_w(DEPTH_W);

    logic [PTR_W-1:0] r_wb;
    logic [PTR_W-1:0] r_rb;
    logic [PTR_W-1:0] r_wg;
    logic [PTR_W-1:0] r_rg;
    logic [PTR_W-1:0] r_usedw;
    logic             r_full;
    logic             r_empty;
    logic             r_w_fail;
    logic             r_r_fail;

    logic             w_w_acc;
    logic             w_r_acc;
    logic [PTR_W-1:0] w_wb_n;
    logic [PTR_W-1:0] w_rb_n;
    logic [PTR_W-1:0] w_wg_n;
    logic [PTR_W-1:0] w_rg_n;
    logic [PTR_W-1:0] w_wb_dec;
    logic [PTR_W-1:0] w_rb_dec;
    logic [PTR_W-1:0] w_usedw_n;
    logic             w_full_n;
    logic             w_empty_n;

    // A request is only accepted against the registered flags, so a write
    // into a full FIFO never passes through even if a read is accepted.
    assign w_w_acc = w_req & ~r_full;
    assign w_r_acc = r_req & ~r_empty;

    assign w_wb_n = r_wb + PTR_W'(w_w_acc);
    assign w_rb_n = r_rb + PTR_W'(w_r_acc);
    assign w_wg_n = PTR_W'(bin2gray(MAX_PTR_W'(w_wb_n)));
    assign w_rg_n = PTR_W'(bin2gray(MAX_PTR_W'(w_rb_n)));

    gray_fifo_gray2bin #(
        .WIDTH (PTR_W)
    ) u_wdec (
        .i_gray (w_wg_n),
        .o_bin  (w_wb_dec)
    );

    gray_fifo_gray2bin #(
        .WIDTH (PTR_W)
    ) u_rdec (
        .i_gray (w_rg_n),
        .o_bin  (w_rb_dec)
    );

    assign w_usedw_n = w_wb_dec - w_rb_dec;
    assign w_empty_n = (w_wg_n == w_rg_n);

    // Full means the pointers are one lap apart: in Gray code that is the
    // top two bits inverted and the rest equal. At depth 2 the pointer is
    // only those two bits.
    if (DEPTH_W == 1) begin : g_full_d2
        assign w_full_n = (w_wg_n == ~w_rg_n);
    end else begin : g_full_dn
        assign w_full_n = (w_wg_n == {~w_rg_n[PTR_W-1:PTR_W-2], w_rg_n[PTR_W-3:0]});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb     <= '0;
            r_rb     <= '0;
            r_wg     <= '0;
            r_rg     <= '0;
            r_usedw  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_w_fail <= 1'b0;
            r_r_fail <= 1'b0;
        end else begin
            r_wb     <= w_wb_n;
            r_rb     <= w_rb_n;
            r_wg     <= w_wg_n;
            r_rg     <= w_rg_n;
            r_usedw  <= w_usedw_n;
            r_full   <= w_full_n;
            r_empty  <= w_empty_n;
            r_w_fail <= w_req & r_full;
            r_r_fail <= r_req & r_empty;
        end
    end

    assign w_en       = w_w_acc;
    assign r_en       = w_r_acc;
    assign w_addr     = r_wb[DEPTH_W-1:0];
    assign r_addr     = r_rb[DEPTH_W-1:0];
    assign w_ptr_gray = r_wg;
    assign r_ptr_gray = r_rg;
    assign full       = r_full;
    assign empty      = r_empty;
    assign usedw      = r_usedw;
    assign w_fail     = r_w_fail;
    assign r_fail     = r_r_fail;

endmodule

// File: tb/tb_gray_fifo_ctrl.sv
// Directed and random bench for gray_fifo_ctrl at depth 4, with a data
// scoreboard riding on a bench-side RAM driven by the controller addresses.
module tb_gray_fifo_ctrl;

  localparam int DW    = 2;
  localparam int PW    = 3;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          w_req;
  logic          r_req;
  logic          w_en;
  logic          r_en;
  logic [DW-1:0] w_addr;
  logic [DW-1:0] r_addr;
  logic [PW-1:0] w_ptr_gray;
  logic [PW-1:0] r_ptr_gray;
  logic          full;
  logic          empty;
  logic [PW-1:0] usedw;
  logic          w_fail;
  logic          r_fail;

  gray_fifo_ctrl #(
    .DEPTH_W (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .w_req      (w_req),
    .r_req      (r_req),
    .w_en       (w_en),
    .r_en       (r_en),
    .w_addr     (w_addr),
    .r_addr     (r_addr),
    .w_ptr_gray (w_ptr_gray),
    .r_ptr_gray (r_ptr_gray),
    .full       (full),
    .empty      (empty),
    .usedw      (usedw),
    .w_fail     (w_fail),
    .r_fail     (r_fail)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // scoreboard and reference model
  logic [7:0]    exp_q[$];
  logic [7:0]    mem[DEPTH];
  logic [PW-1:0] m_wb;
  logic [PW-1:0] m_rb;
  int            m_cnt;
  logic          m_wf;
  logic          m_rf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check_state();
    logic [PW-1:0] fcmp;
    fcmp = {~r_ptr_gray[2:1], r_ptr_gray[0]};
    check_eq("usedw",      32'(usedw),      32'(m_cnt));
    check_eq("full",       32'(full),       32'(m_cnt == DEPTH));
    check_eq("empty",      32'(empty),      32'(m_cnt == 0));
    check_eq("w_addr",     32'(w_addr),     32'(m_wb[DW-1:0]));
    check_eq("r_addr",     32'(r_addr),     32'(m_rb[DW-1:0]));
    check_eq("w_ptr_gray", 32'(w_ptr_gray), 32'(to_gray(m_wb)));
    check_eq("r_ptr_gray", 32'(r_ptr_gray), 32'(to_gray(m_rb)));
    check_eq("w_fail",     32'(w_fail),     32'(m_wf));
    check_eq("r_fail",     32'(r_fail),     32'(m_rf));
    check_eq("full_eq",    32'(full),       32'(w_ptr_gray == fcmp));
    check_eq("empty_eq",   32'(empty),      32'(w_ptr_gray == r_ptr_gray));
  endtask

  // driver: one clock cycle with the given requests
  task automatic step(input logic w, input logic r);
    logic          acc_w;
    logic          acc_r;
    logic [7:0]    data;
    logic [7:0]    exp_d;
    logic [PW-1:0] prev_wg;
    logic [PW-1:0] prev_rg;
    @(negedge clk);
    w_req = w;
    r_req = r;
    #1;
    acc_w = w && (m_cnt != DEPTH);
    acc_r = r && (m_cnt != 0);
    check_eq("w_en", 32'(w_en), 32'(acc_w));
    check_eq("r_en", 32'(r_en), 32'(acc_r));
    if (acc_r) begin
      check_eq("rdata_avail", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_d = exp_q.pop_front();
        check_eq("rdata", 32'(mem[r_addr]), 32'(exp_d));
      end
    end
    if (acc_w) begin
      data = 8'($urandom_range(0, 255));
      mem[w_addr] = data;
      exp_q.push_back(data);
    end
    prev_wg = w_ptr_gray;
    prev_rg = r_ptr_gray;
    @(posedge clk);
    #1;
    m_wb  = m_wb + PW'(acc_w);
    m_rb  = m_rb + PW'(acc_r);
    m_cnt = m_cnt + int'(acc_w) - int'(acc_r);
    m_wf  = w && !acc_w;
    m_rf  = r && !acc_r;
    check_state();
    check_eq("wg_step", $countones(w_ptr_gray ^ prev_wg), 32'(acc_w));
    check_eq("rg_step", $countones(r_ptr_gray ^ prev_rg), 32'(acc_r));
  endtask

  task automatic do_reset(input logic w, input logic r);
    @(negedge clk);
    rst   = 1'b1;
    w_req = w;
    r_req = r;
    @(posedge clk);
    #1;
    m_wb  = '0;
    m_rb  = '0;
    m_cnt = 0;
    m_wf  = 1'b0;
    m_rf  = 1'b0;
    exp_q.delete();
    check_state();
    rst   = 1'b0;
    w_req = 1'b0;
    r_req = 1'b0;
  endtask

  logic [PW-1:0] g_tab[4];
  logic          w_wrap;
  logic          r_wrap;
  logic [PW-1:0] pw;
  logic [PW-1:0] pr;

  initial begin
    rst   = 1'b1;
    w_req = 1'b0;
    r_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    g_tab[0] = 3'b001;
    g_tab[1] = 3'b011;
    g_tab[2] = 3'b010;
    g_tab[3] = 3'b110;

    // 1: reset then four writes
    do_reset(1'b0, 1'b0);
    check_eq("rst_wg", 32'(w_ptr_gray), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      check_eq("s1_usedw", 32'(usedw), 32'(i + 1));
      check_eq("s1_wgray", 32'(w_ptr_gray), 32'(g_tab[i]));
    end
    check_eq("s1_full", 32'(full), 32'd1);

    // 2: write into full
    step(1'b1, 1'b0);
    check_eq("s2_wfail", 32'(w_fail), 32'd1);
    check_eq("s2_usedw", 32'(usedw), 32'd4);
    check_eq("s2_wgray", 32'(w_ptr_gray), 32'b110);
    step(1'b0, 1'b0);
    check_eq("s2_wfail_end", 32'(w_fail), 32'd0);

    // 3: drain, read from empty, then simultaneous on empty
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check_eq("s3_rfail", 32'(r_fail), 32'd1);
    check_eq("s3_empty", 32'(empty), 32'd1);
    step(1'b1, 1'b1);
    check_eq("s3_usedw", 32'(usedw), 32'd1);
    check_eq("s3_rfail2", 32'(r_fail), 32'd1);

    // 4: steady-state streaming across pointer wrap
    step(1'b1, 1'b0);
    check_eq("s4_usedw0", 32'(usedw), 32'd2);
    w_wrap = 1'b0;
    r_wrap = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pw = w_ptr_gray;
      pr = r_ptr_gray;
      step(1'b1, 1'b1);
      check_eq("s4_usedw", 32'(usedw), 32'd2);
      if (pw == 3'b100 && w_ptr_gray == 3'b000) w_wrap = 1'b1;
      if (pr == 3'b100 && r_ptr_gray == 3'b000) r_wrap = 1'b1;
    end
    check_eq("s4_wwrap", 32'(w_wrap), 32'd1);
    check_eq("s4_rwrap", 32'(r_wrap), 32'd1);

    // 5: simultaneous on full reads only
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check_eq("s5_full0", 32'(full), 32'd1);
    step(1'b1, 1'b1);
    check_eq("s5_usedw", 32'(usedw), 32'd3);
    check_eq("s5_full", 32'(full), 32'd0);
    check_eq("s5_wfail", 32'(w_fail), 32'd1);

    // 6: reset wins over requests
    do_reset(1'b1, 1'b1);
    check_eq("s6_usedw", 32'(usedw), 32'd0);
    check_eq("s6_empty", 32'(empty), 32'd1);
    check_eq("s6_full", 32'(full), 32'd0);
    check_eq("s6_wgray", 32'(w_ptr_gray), 32'd0);
    check_eq("s6_rgray", 32'(r_ptr_gray), 32'd0);

    // random push/pop with shifting bias
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 150; i++) begin
        step($urandom_range(0, 99) < (ph == 0 ? 75 : (ph == 1 ? 30 : 50)),
             $urandom_range(0, 99) < (ph == 0 ? 30 : (ph == 1 ? 75 : 50)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
